// File: rtl/timer_ctrl.sv
// Timer sequencing controller: prescaler + up-counter with compare, one-shot/periodic, sticky irq/ovr.
// Optional capture port set enabled by defining TIMER_CAPTURE_EN.
module timer_ctrl #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [PSC_W-1:0] psc,
    input  logic [CNT_W-1:0] period,
    input  logic             irq_ack,
`ifdef TIMER_CAPTURE_EN
    input  logic             capt,
    output logic [CNT_W-1:0] capt_val,
    output logic             capt_vld,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             busy,
    output logic             irq,
    output logic             ovr
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic             mode;
        logic [PSC_W-1:0] psc;
        logic [CNT_W-1:0] period;
    } cfg_t;

    state_t           state, state_nxt;
    cfg_t             cfg, cfg_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [PSC_W-1:0] psc_cnt, psc_cnt_nxt;
    logic             tick_nxt;
    logic             busy_nxt;
    logic             irq_nxt;
    logic             ovr_nxt;
    logic             expiry;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cfg     <= '0;
            cnt     <= '0;
            psc_cnt <= '0;
            tick    <= 1'b0;
            busy    <= 1'b0;
            irq     <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg     <= cfg_nxt;
            cnt     <= cnt_nxt;
            psc_cnt <= psc_cnt_nxt;
            tick    <= tick_nxt;
            busy    <= busy_nxt;
            irq     <= irq_nxt;
            ovr     <= ovr_nxt;
        end
    end

    // Next-state, counter sequencing and interrupt logic
    always_comb begin
        state_nxt   = state;
        cfg_nxt     = cfg;
        cnt_nxt     = cnt;
        psc_cnt_nxt = psc_cnt;
        tick_nxt    = 1'b0;
        expiry      = 1'b0;
        irq_nxt     = irq;
        ovr_nxt     = ovr;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    cfg_nxt.mode   = mode;
                    cfg_nxt.psc    = psc;
                    cfg_nxt.period = period;
                    cnt_nxt        = '0;
                    psc_cnt_nxt    = '0;
                    state_nxt      = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    cfg_nxt.mode   = mode;
                    cfg_nxt.psc    = psc;
                    cfg_nxt.period = period;
                    cnt_nxt        = '0;
                    psc_cnt_nxt    = '0;
                end else if (psc_cnt == cfg.psc) begin
                    psc_cnt_nxt = '0;
                    tick_nxt    = 1'b1;
                    // Compare before increment so cnt never passes period and cannot wrap
                    if (cnt == cfg.period) begin
                        expiry = 1'b1;
                        if (cfg.mode) begin
                            cnt_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    psc_cnt_nxt = psc_cnt + PSC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Expiry takes priority over a coincident acknowledge
        if (expiry) begin
            irq_nxt = 1'b1;
            if (irq && !irq_ack) begin
                ovr_nxt = 1'b1;
            end
        end else if (irq_ack && irq) begin
            irq_nxt = 1'b0;
            ovr_nxt = 1'b0;
        end

        busy_nxt = (state_nxt == RUN);
    end

`ifdef TIMER_CAPTURE_EN
    logic             capt_q;
    logic             capt_qq;
    logic             capt_rise;
    logic [CNT_W-1:0] capt_val_nxt;
    logic             capt_vld_nxt;

    // Capture registers: two-stage edge detect, then snapshot of cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            capt_q   <= 1'b0;
            capt_qq  <= 1'b0;
            capt_val <= '0;
            capt_vld <= 1'b0;
        end else begin
            capt_q   <= capt;
            capt_qq  <= capt_q;
            capt_val <= capt_val_nxt;
            capt_vld <= capt_vld_nxt;
        end
    end

    always_comb begin
        capt_val_nxt = capt_val;
        capt_vld_nxt = 1'b0;
        capt_rise    = capt_q && !capt_qq;
        if (capt_rise && busy) begin
            capt_val_nxt = cnt;
            capt_vld_nxt = 1'b1;
        end
    end
`endif

endmodule
